a2d_spi_resp: RTL
=================

Name: a2d_spi_resp

Overview:
- SPI responder that models the 8-channel 12-bit A2D converter on the far end of the A2D SPI link driven by our A2D master interface.
- Decodes 16-bit channel-select frames on MOSI. On the following frame, returns the 12-bit sample of the channel selected in the previous frame on MISO.
- Used as the converter model in system benches and as an FPGA stand-in when no converter is fitted.
- Channel sample values come from an external port, driven by the bench or by fixed slide-pot values.

Parameters:
- DATA_W, 12: sample width.
- FRAME_W, 16: SPI bits per frame (SS_n low window).
- NUM_CH, 8: number of channels; channel field is 3 bits.

Ports:
- clk, input, 1: system clock. All logic is on posedge.
- rst, input, 1: synchronous, active-high reset.
- SS_n, input, 1: SPI select, active low, asynchronous to clk.
- SCLK, input, 1: SPI clock, asynchronous to clk. Period is at least 8 clk.
- MOSI, input, 1: command bits from the master, MSB first.
- ch_data, input, NUM_CH*DATA_W: channel samples, packed; channel k = ch_data[k*12 +: 12].
- MISO, output, 1: response bits, MSB first.
- chnl_sel, output, 3: channel latched from the last good command frame.
- cmd_vld, output, 1: one-clk pulse when a good 16-bit frame completes.
- frame_err, output, 1: one-clk pulse when a frame ends with bit count other than 16.
- frm_cnt, output, 8: count of good frames, wraps at 255 to 0.

Behaviour:
- Synchronisers
  - SS_n, SCLK and MOSI each pass through 2 flops. SCLK and SS_n get a third flop for edge detect.
  - sclk_rise and sclk_fall are one-clk pulses. ss_fall and ss_rise are one-clk pulses.
  - All SPI events act 2–3 clk after the pin edge.
- Reset (rst high on a posedge)
  - state=RESYNC; rx_shft=0, tx_shft=0, bit_cnt=0.
  - chnl_sel=0, frm_cnt=0, cmd_vld=0, frame_err=0.
  - Sync flops: SS_n stages=1, SCLK stages=0.
- State IDLE
  - MISO=0, no shifting.
  - On ss_fall: load tx_shft with {4'b0000, ch_data[chnl_sel]}, clear bit_cnt, go to SHIFT.
  - Sample is captured at that instant; later ch_data changes do not affect the frame in flight.
- State SHIFT
  - MISO=tx_shft[15], so the MSB is valid before the first SCLK rise (mode 0).
  - sclk_rise: rx_shft <= {rx_shft[14:0], MOSI_sync}; bit_cnt saturates at 31.
  - sclk_fall: tx_shft <= {tx_shft[14:0], 1'b0}, but only if bit_cnt != 0. This ignores a stray fall before the first rise.
  - ss_rise with bit_cnt==16: chnl_sel <= rx_shft[13:11]; cmd_vld=1 for 1 clk; frm_cnt+1 (wraps); go to IDLE.
  - ss_rise with bit_cnt!=16 (short or long frame): frame_err=1 for 1 clk; chnl_sel and frm_cnt unchanged; go to IDLE.
  - sclk_rise and ss_rise in the same clk: the rise is counted first, then the end-of-frame check uses the new bit_cnt.
- State RESYNC
  - MISO=0.
  - Waits for synchronised SS_n high for 1 clk, then goes to IDLE.
  - A frame already in progress when reset released is discarded with no frame_err.
- Command format (MSB first): bits[15:14] ignored, [13:11] channel, [10:0] ignored.
- Response format: 4 zero bits, then the 12-bit sample MSB first.
- MISO is driven 0 (not tristate) outside SHIFT.
- Latency: response to command N appears in frame N+1. The first frame after reset returns channel 0.

Test Plan:
1. Reset, ch_data ch0=12'hABC. Frame 1 MOSI=16'h2800 (ch5) → MISO shifts 16'h0ABC; cmd_vld pulse; chnl_sel=5; frm_cnt=1.
2. ch5=12'h5A5. Frame 2 MOSI=16'h0000 → MISO 16'h05A5; chnl_sel=0; frm_cnt=2.
3. ch0 changes 12'h111→12'h222 mid-frame, after ss_fall → MISO returns 12'h111 in full.
4. SS_n released after 10 SCLK rises → frame_err pulse; no cmd_vld; chnl_sel and frm_cnt unchanged. Next good frame still returns the old channel. Repeat with 17 rises → frame_err.
5. Assert rst for 1 clk at bit 7 of a frame → all outputs zero. Remaining SCLK edges ignored, no frame_err. Next full frame is decoded normally.
6. Run 256 back-to-back good frames, cycling channels 0–7 with distinct samples → every response matches the prior command; frm_cnt wraps 255→0.

Source files
------------

// File: rtl/a2d_spi_resp.sv
// SPI responder modelling an 8-channel 12-bit A2D converter: decodes channel-select
// frames on MOSI and returns the sample selected by the previous frame on MISO.
module a2d_spi_resp #(
  parameter int DATA_W  = 12,
  parameter int FRAME_W = 16,
  parameter int NUM_CH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     SS_n,
  input  logic                     SCLK,
  input  logic                     MOSI,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     MISO,
  output logic [2:0]               chnl_sel,
  output logic                     cmd_vld,
  output logic                     frame_err,
  output logic [7:0]               frm_cnt
);

  localparam logic [4:0] FRAME_LEN = 5'(FRAME_W);
  localparam int         CH_LSB    = FRAME_W - 5;

  typedef enum logic [1:0] {RESYNC, IDLE, SHIFT} state_t;

  state_t               state;
  logic [2:0]           ss_sync;
  logic [2:0]           sclk_sync;
  logic [1:0]           mosi_sync;
  logic [1:0]           settle_cnt;
  logic [FRAME_W-1:0]   rx_shft;
  logic [FRAME_W-1:0]   tx_shft;
  logic [4:0]           bit_cnt;
  logic [FRAME_W-1:0]   rx_nxt;
  logic [4:0]           bit_cnt_nxt;
  logic [DATA_W-1:0]    ch_arr [NUM_CH];

  logic ss_fall, ss_rise, sclk_rise, sclk_fall;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_arr[k] = ch_data[k*DATA_W +: DATA_W];
  end

  // Two-flop synchronisers; the third stage on SS_n/SCLK is only for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync   <= 3'b111;
      sclk_sync <= 3'b000;
      mosi_sync <= 2'b00;
    end else begin
      ss_sync   <= {ss_sync[1:0], SS_n};
      sclk_sync <= {sclk_sync[1:0], SCLK};
      mosi_sync <= {mosi_sync[0], MOSI};
    end
  end

  assign ss_fall   =  ss_sync[2]   & ~ss_sync[1];
  assign ss_rise   = ~ss_sync[2]   &  ss_sync[1];
  assign sclk_rise = ~sclk_sync[2] &  sclk_sync[1];
  assign sclk_fall =  sclk_sync[2] & ~sclk_sync[1];

  // A rise coinciding with SS_n release must be counted before the end-of-frame check.
  always_comb begin
    // NOTE: defaults first so every path assigns these and no latch is inferred.
    rx_nxt      = rx_shft;
    bit_cnt_nxt = bit_cnt;
    if (sclk_rise) begin
      rx_nxt = {rx_shft[FRAME_W-2:0], mosi_sync[1]};
      if (bit_cnt != 5'd31) bit_cnt_nxt = bit_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (rst) begin
      state      <= RESYNC;
      settle_cnt <= 2'd0;
      rx_shft    <= '0;
      tx_shft    <= '0;
      bit_cnt    <= 5'd0;
      chnl_sel   <= 3'd0;
      frm_cnt    <= 8'd0;
      cmd_vld    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cmd_vld   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        // Let the sync pipeline flush so a frame cut by reset never looks like a new one.
        RESYNC: begin
          if (settle_cnt != 2'd3)
            settle_cnt <= settle_cnt + 2'd1;
          else if (ss_sync[1] && ss_sync[2])
            state <= IDLE;
        end
        IDLE: begin
          if (ss_fall) begin
            tx_shft <= {{(FRAME_W-DATA_W){1'b0}}, ch_arr[chnl_sel]};
            bit_cnt <= 5'd0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          rx_shft <= rx_nxt;
          bit_cnt <= bit_cnt_nxt;
          if (sclk_fall && bit_cnt != 5'd0)
            tx_shft <= {tx_shft[FRAME_W-2:0], 1'b0};
          if (ss_rise) begin
            state <= IDLE;
            if (bit_cnt_nxt == FRAME_LEN) begin
              chnl_sel <= rx_nxt[CH_LSB+2:CH_LSB];
              cmd_vld  <= 1'b1;
              frm_cnt  <= frm_cnt + 8'd1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= RESYNC;
      endcase
    end
  end

  assign MISO = (state == SHIFT) ? tx_shft[FRAME_W-1] : 1'b0;

endmodule
